arith_seq_ctrl: RTL and testbench

- Command sequencer for the team's shared 4-bit arithmetic unit (select lines S1/S0, carry-in CIN, operands A/B; sum F; carry-out CO).
- Accepts WIDTH-bit arithmetic commands over a valid/ready handshake and runs them as WIDTH/4 nibble passes through the unit, least-significant nibble first, chaining the unit's CO into the next pass's CIN.
- Returns the assembled result, final carry and zero flag on a second valid/ready handshake.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/arith_op_decode.sv | 12 +
 rtl/arith_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_arith_seq_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared opcodes, sequencer state encoding and opcode decode for the 4-bit arithmetic unit
package arith_pkg;
    localparam int NIB = 4;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;
    localparam logic [2:0] OP_INC = 3'd4;
    localparam logic [2:0] OP_DEC = 3'd5;
    localparam logic [2:0] OP_TFR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    // Returns {s1, s0, first-pass cin}; the reserved opcode runs as a transfer
    function automatic logic [2:0] op_decode(input logic [2:0] op, input logic cin);
        case (op)
            OP_ADD:  return 3'b000;
            OP_ADC:  return {2'b00, cin};
            OP_SUB:  return 3'b011;
            OP_SBB:  return {2'b01, cin};
            OP_INC:  return 3'b101;
            OP_DEC:  return 3'b110;
            default: return 3'b100;
        endcase
    endfunction
endpackage

// File: rtl/arith_op_decode.sv
// arith_op_decode: combinational opcode to unit select/carry decode
module arith_op_decode import arith_pkg::*; (
    input  logic [2:0] op_i,
    input  logic       cin_i,
    output logic       s1_o,
    output logic       s0_o,
    output logic       cin_o,
    output logic       err_o
);
    assign {s1_o, s0_o, cin_o} = op_decode(op_i, cin_i);
    assign err_o = op_i == OP_RSV;
endmodule

// File: rtl/arith_seq_ctrl.sv
// arith_seq_ctrl: runs WIDTH-bit commands as chained nibble passes through the 4-bit arithmetic unit
module arith_seq_ctrl import arith_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    output logic             au_s1,
    output logic             au_s0,
    output logic             au_cin,
    output logic [3:0]       au_a,
    output logic [3:0]       au_b,
    input  logic [3:0]       au_f,
    input  logic             au_co,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_co,
    output logic             res_zero,
    output logic             res_err
);
    localparam int NP = WIDTH / NIB;
    localparam int KW = NP > 1 ? $clog2(NP) : 1;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             cin_q, cin_d, carry_q, carry_d, co_q, co_d, zero_q, zero_d, err_q, err_d;
    logic [KW-1:0]    k_q, k_d;
    logic             dec_s1, dec_s0, dec_cin, dec_err, run;

    arith_op_decode u_dec (
        .op_i  (op_q),
        .cin_i (cin_q),
        .s1_o  (dec_s1),
        .s0_o  (dec_s0),
        .cin_o (dec_cin),
        .err_o (dec_err)
    );

    assign run       = state_q == RUN;
    assign au_s1     = run & dec_s1;
    assign au_s0     = run & dec_s0;
    assign au_cin    = run & (k_q == '0 ? dec_cin : carry_q);
    assign au_a      = run ? a_q[NIB*int'(k_q) +: NIB] : '0;
    assign au_b      = run ? b_q[NIB*int'(k_q) +: NIB] : '0;
    assign cmd_ready = state_q == IDLE;
    assign res_valid = state_q == DONE;
    assign res_data  = res_q;
    assign res_co    = co_q;
    assign res_zero  = zero_q;
    assign res_err   = err_q;

    // Next state: latch on accept, fold one nibble per RUN cycle, hold the result until taken
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        k_d     = k_q;
        carry_d = carry_q;
        res_d   = res_q;
        co_d    = co_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = RUN;
                op_d    = cmd_op;
                a_d     = cmd_a;
                b_d     = cmd_b;
                cin_d   = cmd_cin;
                k_d     = '0;
                carry_d = 1'b0;
            end
            RUN: begin
                res_d[NIB*int'(k_q) +: NIB] = au_f;
                carry_d = au_co;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(NP - 1)) begin
                    state_d = DONE;
                    co_d    = au_co;
                    zero_d  = res_d == '0;
                    err_d   = dec_err;
                end
            end
            default: if (res_ready) state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_arith_seq_ctrl.sv
// tb_arith_seq_ctrl: randomized and directed checks of the sequencer against a full-width arithmetic model
module tb_arith_seq_ctrl;
    localparam int W  = 8;
    localparam int NP = W / 4;

    logic         clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_cin = 1'b0, res_ready = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         cmd_ready, au_s1, au_s0, au_cin, au_co, res_valid, res_co, res_zero, res_err;
    logic [3:0]   au_a, au_b, au_f, au_bop;
    logic [W-1:0] res_data;
    logic [3:0]   pass_a [NP];
    logic         pass_cin [NP];
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    arith_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .au_s1(au_s1), .au_s0(au_s0), .au_cin(au_cin), .au_a(au_a), .au_b(au_b),
        .au_f(au_f), .au_co(au_co),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_co(res_co), .res_zero(res_zero), .res_err(res_err)
    );

    // Behavioural 4-bit arithmetic unit
    assign au_bop = {au_s1, au_s0} == 2'b00 ? au_b :
                    {au_s1, au_s0} == 2'b01 ? ~au_b :
                    {au_s1, au_s0} == 2'b10 ? 4'h0 : 4'hF;
    assign {au_co, au_f} = 5'(au_a) + 5'(au_bop) + 5'(au_cin);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-word result: {carry, data} of the full-width operation
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W-1:0] bo;
        logic         c;
        case (op)
            3'd0: begin bo = b;  c = 1'b0; end
            3'd1: begin bo = b;  c = ci;   end
            3'd2: begin bo = ~b; c = 1'b1; end
            3'd3: begin bo = ~b; c = ci;   end
            3'd4: begin bo = '0; c = 1'b1; end
            3'd5: begin bo = '1; c = 1'b0; end
            default: begin bo = '0; c = 1'b0; end
        endcase
        return {1'b0, a} + {1'b0, bo} + (W+1)'(c);
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold);
        logic [W:0] e;
        int n;
        e = model(op, a, b, ci);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = ci;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_cin = ~ci;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!res_valid && n <= NP) begin
                pass_a[n-1]   = au_a;
                pass_cin[n-1] = au_cin;
            end
        end while (!res_valid && n < 20);
        chk("latency", 32'(n), 32'(NP + 1));
        chk("res_data", 32'(res_data), 32'(e[W-1:0]));
        chk("res_co", 32'(res_co), 32'(e[W]));
        chk("res_zero", 32'(res_zero), 32'(e[W-1:0] == '0));
        chk("res_err", 32'(res_err), 32'(op == 3'd7));
        chk("pass0_a", 32'(pass_a[0]), 32'(a[3:0]));
        chk("au_idle_done", 32'({au_s1, au_s0, au_cin, au_a, au_b}), 0);
        if (!res_valid) return;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 3'($urandom);
            @(negedge clk);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data", 32'({res_co, res_data}), 32'(e));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("taken_ready", 32'(cmd_ready), 1);
        chk("taken_valid", 32'(res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_outs", 32'({res_valid, res_data, res_co, res_zero, res_err}), 0);
        chk("rst_au", 32'({au_s1, au_s0, au_cin, au_a, au_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd0, 8'h3C, 8'h4F, 1'b0, 0);
        chk("add_pass1_cin", 32'(pass_cin[1]), 1);
        chk("add_pass0_cin", 32'(pass_cin[0]), 0);
        run_cmd(3'd2, 8'h10, 8'h01, 1'b0, 0);
        run_cmd(3'd2, 8'h01, 8'h02, 1'b0, 0);
        run_cmd(3'd4, 8'hFF, 8'h37, 1'b0, 0);
        run_cmd(3'd5, 8'h00, 8'h91, 1'b1, 0);
        run_cmd(3'd1, 8'hFF, 8'h00, 1'b1, 0);
        run_cmd(3'd3, 8'h20, 8'h05, 1'b0, 2);
        run_cmd(3'd0, 8'h12, 8'h34, 1'b0, 5);
        run_cmd(3'd7, 8'hA5, 8'h3C, 1'b1, 0);
        // Asynchronous reset after the first pass of an in-flight command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 8'h5A; cmd_b = 8'h33;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chk("mid_rst_outs", 32'({res_valid, res_data, res_co, res_zero, res_err}), 0);
        chk("mid_rst_au", 32'({au_s1, au_s0, au_cin, au_a, au_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_res_after_rst", 32'(res_valid), 0);
        end
        run_cmd(3'd0, 8'h01, 8'h01, 1'b0, 0);
        repeat (60) run_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
